// File: rtl/multi_channel_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_channel_collector                                                  |
// | NUM_CH req/grant packet sink with round-robin arbiter, shared FIFO and   |
// | receive statistics. Define COLLECTOR_LATENCY_EN for latency tracking.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_channel_collector #(
  parameter int         dataWidth  = 32,
  parameter int         dim        = 4,
  parameter int         NUM_CH     = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] ModuleID   = 6'b000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*dataWidth-1:0] PacketIn,
  input  logic [NUM_CH-1:0]           ReqUpStr,
  output logic [NUM_CH-1:0]           GntUpStr,
  output logic [NUM_CH-1:0]           UpStrFull,
  input  logic                        DrainEn,
  output logic                        RecValid,
  output logic [(dim-1)*2-1:0]        RecSenderID,
  output logic [9:0]                  RecPacketID,
  output logic [5:0]                  RecModuleID,
  output logic [31:0]                 RxCount,
  output logic [15:0]                 LastLatency,
  output logic [15:0]                 MaxLatency
);

  localparam int c_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W    = c_ADDR_W + 1;
  localparam int c_SENDER_W = (dim - 1) * 2;
  localparam int c_SRC_W    = dim * 4 - 10;

  typedef enum logic [0:0] {
    WAIT_REQ     = 1'b0,
    RECEIVE_DATA = 1'b1
  } chState_t;

  chState_t                r_state     [NUM_CH];
  chState_t                w_stateNext [NUM_CH];
  logic [NUM_CH-1:0]       w_eligible;
  logic                    w_pick;
  logic [c_CH_W-1:0]       w_winner;
  logic [c_CH_W-1:0]       w_idx;
  logic [c_CH_W-1:0]       r_rr;
  logic [dataWidth-1:0]    w_pushData;

  logic [dataWidth-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]     r_wrPtr;
  logic [c_ADDR_W-1:0]     r_rdPtr;
  logic [c_CNT_W-1:0]      r_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [dataWidth-1:0]    w_head;
  logic [c_SENDER_W-1:0]   w_sender;
  logic [31:0]             r_cycleCounter;
  logic                    w_unusedBits;

  always_ff @(posedge clk) begin
    if (reset) r_cycleCounter <= '0;
    else       r_cycleCounter <= r_cycleCounter + 32'd1;
  end

  // Per-channel FSM: state register and eligibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) r_state[i] <= WAIT_REQ;
      else       r_state[i] <= w_stateNext[i];
    end
  end

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_eligible[i] = (r_state[i] == WAIT_REQ) && ReqUpStr[i];
  end

  always_comb begin
    GntUpStr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_stateNext[i] = r_state[i];
      case (r_state[i])
        WAIT_REQ: begin
          if (w_pick && (w_winner == c_CH_W'(i))) w_stateNext[i] = RECEIVE_DATA;
        end
        RECEIVE_DATA: begin
          GntUpStr[i]    = 1'b1;
          w_stateNext[i] = WAIT_REQ;
        end
        default: w_stateNext[i] = WAIT_REQ;
      endcase
    end
  end

  // Round-robin search starting at r_rr; a full FIFO (pre-pop count) blocks the pick
  always_comb begin
    w_pick   = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = c_CH_W'((int'(r_rr) + k) % NUM_CH);
      if (!w_pick && w_eligible[w_idx]) begin
        w_pick   = 1'b1;
        w_winner = w_idx;
      end
    end
    if (w_full) w_pick = 1'b0;
  end

  always_comb begin
    w_pushData = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_winner == c_CH_W'(i)) w_pushData = PacketIn[i*dataWidth +: dataWidth];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_pick) begin
      if (w_winner == c_CH_W'(NUM_CH - 1)) r_rr <= '0;
      else                                 r_rr <= w_winner + 1'b1;
    end
  end

  assign w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_pick;
  assign w_pop     = DrainEn && !w_empty;
  assign w_head    = r_mem[r_rdPtr];
  assign UpStrFull = {NUM_CH{w_full}};

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wrPtr] <= w_pushData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sender field width differs from the output width for dims other than 4
  if (c_SENDER_W <= c_SRC_W) begin : g_senderTrunc
    assign w_sender = w_head[c_SENDER_W-1:0];
  end else begin : g_senderPad
    assign w_sender = {{(c_SENDER_W - c_SRC_W){1'b0}}, w_head[c_SRC_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RecValid    <= 1'b0;
      RxCount     <= '0;
      RecSenderID <= '0;
      RecPacketID <= '0;
    end else begin
      RecValid <= w_pop;
      if (w_pop) begin
        RxCount     <= RxCount + 32'd1;
        RecSenderID <= w_sender;
        RecPacketID <= w_head[dim*4-1 -: 10];
      end
    end
  end

  assign RecModuleID = ModuleID;

`ifdef COLLECTOR_LATENCY_EN
  logic [15:0] w_latency;
  assign w_latency = r_cycleCounter[15:0] - w_head[dataWidth-1 -: 16];

  always_ff @(posedge clk) begin
    if (reset) begin
      LastLatency <= '0;
      MaxLatency  <= '0;
    end else if (w_pop) begin
      LastLatency <= w_latency;
      if (w_latency > MaxLatency) MaxLatency <= w_latency;
    end
  end
`else
  assign LastLatency = '0;
  assign MaxLatency  = '0;
`endif

  assign w_unusedBits = ^{r_cycleCounter, w_head};

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_collector.sv
`default_nettype none
// Directed self-checking bench for multi_channel_collector (2 channels, depth 4).
module tb_multi_channel_collector;

  localparam int         DW    = 32;
  localparam int         DIM   = 4;
  localparam int         NCH   = 2;
  localparam int         DEPTH = 4;
  localparam logic [5:0] MID   = 6'h2A;
`ifdef COLLECTOR_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif
  localparam logic [31:0] PKT_A = 32'h0000_0040;  // packet id 1
  localparam logic [31:0] PKT_B = 32'h0000_0080;  // packet id 2

  logic              clk;
  logic              reset;
  logic [NCH*DW-1:0] PacketIn;
  logic [NCH-1:0]    ReqUpStr;
  logic [NCH-1:0]    GntUpStr;
  logic [NCH-1:0]    UpStrFull;
  logic              DrainEn;
  logic              RecValid;
  logic [5:0]        RecSenderID;
  logic [9:0]        RecPacketID;
  logic [5:0]        RecModuleID;
  logic [31:0]       RxCount;
  logic [15:0]       LastLatency;
  logic [15:0]       MaxLatency;

  int nCompared;
  int nMismatched;

  multi_channel_collector #(
    .dataWidth(DW), .dim(DIM), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .ModuleID(MID)
  ) dut (
    .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr),
    .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .DrainEn(DrainEn),
    .RecValid(RecValid), .RecSenderID(RecSenderID), .RecPacketID(RecPacketID),
    .RecModuleID(RecModuleID), .RxCount(RxCount), .LastLatency(LastLatency),
    .MaxLatency(MaxLatency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; ReqUpStr = '0; DrainEn = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ReqUpStr = 2'b11; DrainEn = 1'b0; PacketIn = {PKT_B, PKT_A};
    for (int k = 0; k < 2; k++) begin
      tick();
      nCompared++; if (GntUpStr !== 2'b00) begin nMismatched++; $display("FAIL rst_gnt_during: got %b want 00", GntUpStr); end
    end
    nCompared++; if (UpStrFull !== 2'b00) begin nMismatched++; $display("FAIL rst_full: got %b want 00", UpStrFull); end
    nCompared++; if (RecValid !== 1'b0) begin nMismatched++; $display("FAIL rst_valid: got %b want 0", RecValid); end
    nCompared++; if (RxCount !== 32'd0) begin nMismatched++; $display("FAIL rst_rxcount: got %0d want 0", RxCount); end
    nCompared++; if (RecSenderID !== 6'h00 || RecPacketID !== 10'h000) begin nMismatched++; $display("FAIL rst_ids: got %h/%h want 0/0", RecSenderID, RecPacketID); end
    nCompared++; if (LastLatency !== 16'd0 || MaxLatency !== 16'd0) begin nMismatched++; $display("FAIL rst_latency: got %0d/%0d want 0/0", LastLatency, MaxLatency); end
    nCompared++; if (RecModuleID !== MID) begin nMismatched++; $display("FAIL module_id: got %h want %h", RecModuleID, MID); end
    reset = 1'b0;
    tick();
    nCompared++; if (GntUpStr !== 2'b01) begin nMismatched++; $display("FAIL rst_first_gnt: got %b want 01", GntUpStr); end
    tick();
    nCompared++; if (GntUpStr !== 2'b10) begin nMismatched++; $display("FAIL rst_second_gnt: got %b want 10", GntUpStr); end
    // Two packets now buffered; reset must discard them
    reset = 1'b1;
    tick();
    nCompared++; if (GntUpStr !== 2'b00 || RecValid !== 1'b0) begin nMismatched++; $display("FAIL midrst_outputs: got gnt %b valid %b want 00 0", GntUpStr, RecValid); end
    reset = 1'b0; ReqUpStr = 2'b00; DrainEn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      nCompared++; if (RecValid !== 1'b0) begin nMismatched++; $display("FAIL midrst_discard: got valid %b want 0", RecValid); end
    end
    nCompared++; if (RxCount !== 32'd0) begin nMismatched++; $display("FAIL midrst_rxcount: got %0d want 0", RxCount); end
  endtask

  task automatic test_single_packet();
    apply_reset();
    DrainEn = 1'b1; PacketIn = {32'h0005_0C47, 32'h0000_0000}; ReqUpStr = 2'b10;
    tick();
    ReqUpStr = 2'b00;
    nCompared++; if (GntUpStr !== 2'b10) begin nMismatched++; $display("FAIL single_gnt: got %b want 10", GntUpStr); end
    nCompared++; if (RecValid !== 1'b0) begin nMismatched++; $display("FAIL single_valid_early: got %b want 0", RecValid); end
    tick();
    nCompared++; if (GntUpStr !== 2'b00) begin nMismatched++; $display("FAIL single_gnt_drop: got %b want 00", GntUpStr); end
    nCompared++; if (RecValid !== 1'b1) begin nMismatched++; $display("FAIL single_valid: got %b want 1", RecValid); end
    nCompared++; if (RecPacketID !== 10'h031) begin nMismatched++; $display("FAIL single_pktid: got %h want 031", RecPacketID); end
    nCompared++; if (RecSenderID !== 6'h07) begin nMismatched++; $display("FAIL single_sender: got %h want 07", RecSenderID); end
    nCompared++; if (RxCount !== 32'd1) begin nMismatched++; $display("FAIL single_rxcount: got %0d want 1", RxCount); end
    tick();
    nCompared++; if (RecValid !== 1'b0 || RxCount !== 32'd1) begin nMismatched++; $display("FAIL single_pulse: got valid %b count %0d want 0 1", RecValid, RxCount); end
  endtask

  task automatic test_round_robin();
    logic [1:0] expGnt;
    logic [9:0] expId;
    apply_reset();
    DrainEn = 1'b1; PacketIn = {PKT_B, PKT_A}; ReqUpStr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      expGnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      nCompared++; if (GntUpStr !== expGnt) begin nMismatched++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, GntUpStr, expGnt); end
      if (k >= 1) begin
        expId = ((k - 1) % 2 == 0) ? 10'd1 : 10'd2;
        nCompared++; if (RecValid !== 1'b1 || RecPacketID !== expId) begin nMismatched++; $display("FAIL rr_pop[%0d]: got valid %b id %0d want 1 %0d", k, RecValid, RecPacketID, expId); end
      end
    end
    ReqUpStr = 2'b00;
    tick();
    nCompared++; if (RecValid !== 1'b1 || RecPacketID !== 10'd2) begin nMismatched++; $display("FAIL rr_last_pop: got valid %b id %0d want 1 2", RecValid, RecPacketID); end
    nCompared++; if (RxCount !== 32'd4) begin nMismatched++; $display("FAIL rr_rxcount: got %0d want 4", RxCount); end
  endtask

  task automatic test_backpressure();
    logic [1:0] expGnt;
    logic [1:0] expFull;
    logic [9:0] expId;
    apply_reset();
    DrainEn = 1'b0; PacketIn = {PKT_B, PKT_A}; ReqUpStr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      expGnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      expFull = (k == 3) ? 2'b11 : 2'b00;
      nCompared++; if (GntUpStr !== expGnt || UpStrFull !== expFull) begin nMismatched++; $display("FAIL bp_fill[%0d]: got gnt %b full %b want %b %b", k, GntUpStr, UpStrFull, expGnt, expFull); end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      nCompared++; if (GntUpStr !== 2'b00 || UpStrFull !== 2'b11 || RecValid !== 1'b0) begin nMismatched++; $display("FAIL bp_stall[%0d]: got gnt %b full %b valid %b want 00 11 0", k, GntUpStr, UpStrFull, RecValid); end
    end
    DrainEn = 1'b1;
    tick();
    nCompared++; if (RecValid !== 1'b1 || RecPacketID !== 10'd1 || UpStrFull !== 2'b00 || GntUpStr !== 2'b00) begin nMismatched++; $display("FAIL bp_first_pop: got valid %b id %0d full %b gnt %b want 1 1 00 00", RecValid, RecPacketID, UpStrFull, GntUpStr); end
    tick();
    nCompared++; if (GntUpStr !== 2'b01 || RecValid !== 1'b1 || RecPacketID !== 10'd2) begin nMismatched++; $display("FAIL bp_resume: got gnt %b valid %b id %0d want 01 1 2", GntUpStr, RecValid, RecPacketID); end
    ReqUpStr = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      expId = (k % 2 == 0) ? 10'd1 : 10'd2;
      nCompared++; if (RecValid !== 1'b1 || RecPacketID !== expId) begin nMismatched++; $display("FAIL bp_drain[%0d]: got valid %b id %0d want 1 %0d", k, RecValid, RecPacketID, expId); end
    end
    tick();
    nCompared++; if (RecValid !== 1'b0 || RxCount !== 32'd5 || UpStrFull !== 2'b00) begin nMismatched++; $display("FAIL bp_end: got valid %b count %0d full %b want 0 5 00", RecValid, RxCount, UpStrFull); end
  endtask

  task automatic test_latency();
    logic [15:0] exp5;
    logic [15:0] exp2;
    exp5 = LAT_EN ? 16'd5 : 16'd0;
    exp2 = LAT_EN ? 16'd2 : 16'd0;
    apply_reset();
    DrainEn = 1'b1;
    tick(); tick();
    // Pushed at counter 2, popped at counter 3: 3 - 0xFFFE wraps to 5
    PacketIn = {32'h0000_0000, 32'hFFFE_0C47}; ReqUpStr = 2'b01;
    tick();
    ReqUpStr = 2'b00;
    tick();
    nCompared++; if (RecValid !== 1'b1) begin nMismatched++; $display("FAIL lat_valid: got %b want 1", RecValid); end
    nCompared++; if (LastLatency !== exp5 || MaxLatency !== exp5) begin nMismatched++; $display("FAIL lat_wrap: got %0d/%0d want %0d/%0d", LastLatency, MaxLatency, exp5, exp5); end
    // Pushed at counter 4, popped at counter 5 with timestamp 3: latency 2
    PacketIn = {32'h0000_0000, 32'h0003_0C47}; ReqUpStr = 2'b01;
    tick();
    ReqUpStr = 2'b00;
    tick();
    nCompared++; if (LastLatency !== exp2 || MaxLatency !== exp5) begin nMismatched++; $display("FAIL lat_max_hold: got %0d/%0d want %0d/%0d", LastLatency, MaxLatency, exp2, exp5); end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b1; ReqUpStr = '0; DrainEn = 1'b0; PacketIn = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
